// File: rtl/generador_tono.sv
// generador_tono: square-wave tone generator for the piano-game note path.
// A valid request (contar=1, note 1..4) starts a tone at the note's pitch.
// Every tone lasts at least MIN_HOLD cycles, so a one-cycle key tap is still heard.
module generador_tono #(
    parameter int HP1      = 95556,
    parameter int HP2      = 85131,
    parameter int HP3      = 75843,
    parameter int HP4      = 71586,
    parameter int CW       = 17,
    parameter int MIN_HOLD = 5000000,
    parameter int DW       = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] notaEntrada,
    input  logic       contar,
    output logic       audio,
    output logic       sonando,
    output logic [2:0] notaActual
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Reload values are stored as "half-period minus one" because the
    // counter counts down to zero inclusive.
    localparam logic [CW-1:0] HP1_M1   = CW'(HP1 - 1);
    localparam logic [CW-1:0] HP2_M1   = CW'(HP2 - 1);
    localparam logic [CW-1:0] HP3_M1   = CW'(HP3 - 1);
    localparam logic [CW-1:0] HP4_M1   = CW'(HP4 - 1);
    localparam logic [DW-1:0] DUR_LOAD = DW'(MIN_HOLD - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dur;

    logic          valid_req;
    logic          same_note;
    logic [CW-1:0] reload_cur;
    logic [CW-1:0] reload_new;

    // Half-period reload for a note code; codes outside 1..4 never reach here
    // while a tone is active, zero keeps the mux fully specified.
    function automatic logic [CW-1:0] hp_reload(input logic [2:0] n);
        logic [CW-1:0] r;
        r = '0;
        case (n)
            3'd1:    r = HP1_M1;
            3'd2:    r = HP2_M1;
            3'd3:    r = HP3_M1;
            3'd4:    r = HP4_M1;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Request decoding and reload selection for the latched and incoming notes.
    always_comb begin
        valid_req  = contar && (notaEntrada >= 3'd1) && (notaEntrada <= 3'd4);
        same_note  = (notaEntrada == notaActual);
        reload_cur = hp_reload(notaActual);
        reload_new = hp_reload(notaEntrada);
    end

    // Tone FSM: state, counters and all outputs registered in one place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            audio      <= 1'b0;
            sonando    <= 1'b0;
            notaActual <= 3'd0;
            cnt        <= '0;
            dur        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    audio      <= 1'b0;
                    notaActual <= 3'd0;
                    sonando    <= 1'b0;
                    if (valid_req) begin
                        state      <= PLAY;
                        sonando    <= 1'b1;
                        notaActual <= notaEntrada;
                        audio      <= 1'b1;
                        cnt        <= reload_new;
                        dur        <= DUR_LOAD;
                    end
                end

                PLAY, HOLD: begin
                    // Free-running square wave on the latched note.
                    if (cnt == '0) begin
                        audio <= ~audio;
                        cnt   <= reload_cur;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                    if (dur != '0) begin
                        dur <= dur - DW'(1);
                    end

                    if (valid_req && !same_note) begin
                        // New note: restart the phase and the minimum hold.
                        state      <= PLAY;
                        sonando    <= 1'b1;
                        notaActual <= notaEntrada;
                        audio      <= 1'b1;
                        cnt        <= reload_new;
                        dur        <= DUR_LOAD;
                    end else if (valid_req) begin
                        // Same note still held: keep phase, no restart.
                        state   <= PLAY;
                        sonando <= 1'b1;
                    end else if (dur == '0) begin
                        state      <= IDLE;
                        sonando    <= 1'b0;
                        audio      <= 1'b0;
                        notaActual <= 3'd0;
                    end else begin
                        state   <= HOLD;
                        sonando <= 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    sonando    <= 1'b0;
                    audio      <= 1'b0;
                    notaActual <= 3'd0;
                    cnt        <= '0;
                    dur        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_generador_tono.sv
// tb_generador_tono: scoreboard bench for generador_tono with small pitches.
// The reference model tracks only "which note, started at which edge" and
// derives the waveform and the end of the minimum hold arithmetically.
module tb_generador_tono;

    localparam int HP1      = 3;
    localparam int HP2      = 4;
    localparam int HP3      = 5;
    localparam int HP4      = 6;
    localparam int MIN_HOLD = 8;

    logic       clk;
    logic       reset;
    logic [2:0] notaEntrada;
    logic       contar;
    logic       audio;
    logic       sonando;
    logic [2:0] notaActual;

    typedef struct {
        int         k;
        logic       audio;
        logic       sonando;
        logic [2:0] nota;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;

    int tests;
    int fails;

    // Model state: tone on/off, its note, and the edge at which it (re)started.
    bit m_on;
    int m_note;
    int m_t0;
    int k;

    generador_tono #(
        .HP1(HP1), .HP2(HP2), .HP3(HP3), .HP4(HP4),
        .CW(17), .MIN_HOLD(MIN_HOLD), .DW(24)
    ) dut (
        .clk(clk),
        .reset(reset),
        .notaEntrada(notaEntrada),
        .contar(contar),
        .audio(audio),
        .sonando(sonando),
        .notaActual(notaActual)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int hp(input int n);
        case (n)
            1:       return HP1;
            2:       return HP2;
            3:       return HP3;
            default: return HP4;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Advance the model by one clock edge and return the outputs expected after it.
    task automatic model_step(input bit r, input bit c, input int n, output exp_t e);
        bit valid;
        k++;
        valid = c && (n >= 1) && (n <= 4);
        if (!r) begin
            m_on = 1'b0;
        end else if (!m_on) begin
            if (valid) begin
                m_on = 1'b1; m_note = n; m_t0 = k;
            end
        end else if (valid && n != m_note) begin
            m_note = n; m_t0 = k;
        end else if (!valid && (k - m_t0) >= MIN_HOLD) begin
            m_on = 1'b0;
        end
        e.k       = k;
        e.sonando = m_on;
        e.nota    = m_on ? 3'(m_note) : 3'd0;
        e.audio   = m_on ? ((((k - m_t0) / hp(m_note)) % 2) == 0) : 1'b0;
    endtask

    // Drive one cycle of stimulus and queue the expected response for it.
    task automatic drive(input bit r, input bit c, input int n);
        exp_t e;
        @(negedge clk);
        reset       = r;
        contar      = c;
        notaEntrada = 3'(n);
        model_step(r, c, n, e);
        last_exp = e;
        q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: compare each queued expectation just after its clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (audio !== e.audio || sonando !== e.sonando || notaActual !== e.nota) begin
                    fails++;
                    $display("FAIL edge%0d: audio/sonando/nota got %b/%b/%0d, expected %b/%b/%0d",
                             e.k, audio, sonando, notaActual, e.audio, e.sonando, e.nota);
                end
            end
        end
    end

    initial begin
        int total;
        tests = 0; fails = 0;
        m_on = 1'b0; m_note = 0; m_t0 = 0; k = 0;
        reset = 1'b0; contar = 1'b1; notaEntrada = 3'd2;

        // Reset held with a pending request, then release: tone at first edge.
        repeat (3) drive(0, 1, 2);
        drive(1, 1, 2);
        repeat (10) drive(1, 0, 0);

        // Sustained note 1, then release.
        repeat (20) drive(1, 1, 1);
        repeat (3) drive(1, 0, 0);

        // Short tap on note 2.
        drive(1, 1, 2);
        repeat (10) drive(1, 0, 0);

        // Note change 1 -> 4, then re-assert 4 during the hold.
        repeat (5) drive(1, 1, 1);
        repeat (8) drive(1, 1, 4);
        repeat (2) drive(1, 0, 0);
        repeat (3) drive(1, 1, 4);
        repeat (12) drive(1, 0, 0);

        // Invalid codes and contar=0 from IDLE.
        drive(1, 1, 5);
        drive(1, 1, 0);
        drive(1, 1, 7);
        drive(1, 0, 3);

        // Asynchronous reset between edges while audio is high.
        drive(1, 1, 3);
        #2;
        check("pre_reset_audio", int'(audio), int'(last_exp.audio));
        reset = 1'b0;
        m_on = 1'b0;
        #1;
        check("async_audio", int'(audio), 0);
        check("async_sonando", int'(sonando), 0);
        check("async_nota", int'(notaActual), 0);
        repeat (2) drive(0, 0, 3);
        repeat (3) drive(1, 0, 3);

        // Randomized segments of held/idle keys with arbitrary codes.
        total = 0;
        while (total < 600) begin
            int n;
            int len;
            bit c;
            n   = $urandom_range(0, 7);
            c   = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 5) == 0) drive(1, 1'($urandom_range(0, 1)), $urandom_range(0, 7));
                else drive(1, c, n);
            end
            total += len;
        end

        // Let the monitor drain the queue within a bounded number of edges.
        for (int i = 0; i < 5 && q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
